// File: rtl/vga_output.sv
// VGA raster transmitter: 640x480@60 timing by default, RGB565 pixels popped from the
// sequencer FIFO and expanded to 8:8:8. It also flags FIFO underflow and marks frame starts.
module vga_output #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        underflow_clr,
  input  logic        seq_rd_empty,
  input  logic [15:0] seq_rd_data,
  output logic        seq_rd_en,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [7:0]  vga_pixel_r,
  output logic [7:0]  vga_pixel_g,
  output logic [7:0]  vga_pixel_b,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [10:0] x, y, x_next, y_next;
  logic        running, act, h_win, v_win;
  logic        pending_underflow, show_pixel;

  // A frame may only stop on its last pixel, so enable is sampled there.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    x_next     = x;
    y_next     = y;
    case (state)
      IDLE: begin
        x_next = '0;
        y_next = '0;
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (x == H_LAST) begin
          x_next = '0;
          if (y == V_LAST) begin
            y_next = '0;
            if (!enable) state_next = IDLE;
          end else begin
            y_next = y + 11'd1;
          end
        end else begin
          x_next = x + 11'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
    end
  end

  assign running     = (state == RUN);
  assign act         = running && (x < H_ACT_END) && (y < V_ACT_END);
  assign h_win       = (x >= HS_START) && (x < HS_END);
  assign v_win       = (y >= VS_START) && (y < VS_END);
  assign seq_rd_en   = act && !seq_rd_empty;
  assign frame_start = running && (x == '0) && (y == '0);

  // Stage 1: timing strobes delayed one clock to line up with the FIFO read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_de            <= 1'b0;
      vga_hsync         <= 1'b1;
      vga_vsync         <= 1'b1;
      pending_underflow <= 1'b0;
      underflow         <= 1'b0;
    end else begin
      vga_de            <= act;
      vga_hsync         <= ~(running && h_win);
      vga_vsync         <= ~(running && v_win);
      pending_underflow <= act && seq_rd_empty;
      if (act && seq_rd_empty) underflow <= 1'b1;
      else if (underflow_clr)  underflow <= 1'b0;
    end
  end

  // The FIFO q is already registered, so gating it with stage-1 puts the pixel on the de cycle.
  assign show_pixel  = vga_de && !pending_underflow;
  assign vga_pixel_r = show_pixel ? {seq_rd_data[15:11], seq_rd_data[15:13]} : 8'h00;
  assign vga_pixel_g = show_pixel ? {seq_rd_data[10:5],  seq_rd_data[10:9]}  : 8'h00;
  assign vga_pixel_b = show_pixel ? {seq_rd_data[4:0],   seq_rd_data[4:2]}   : 8'h00;

endmodule

// File: tb/tb_vga_output.sv
// Self-checking bench for vga_output on a shrunken raster; a frame-position model predicts
// every output each cycle while table vectors and hand sequences cover the corner cases.
module tb_vga_output;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, underflow_clr = 1'b0, seq_rd_empty = 1'b0;
  logic [15:0] seq_rd_data = '0;
  logic        seq_rd_en, frame_start, vga_hsync, vga_vsync, vga_de, underflow;
  logic [7:0]  vga_pixel_r, vga_pixel_g, vga_pixel_b;

  vga_output #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .underflow_clr(underflow_clr),
    .seq_rd_empty(seq_rd_empty), .seq_rd_data(seq_rd_data), .seq_rd_en(seq_rd_en),
    .frame_start(frame_start), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .vga_pixel_r(vga_pixel_r), .vga_pixel_g(vga_pixel_g),
    .vga_pixel_b(vga_pixel_b), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  r, g, b;
  } vec_t;

  vec_t tbl[7];

  int n_tests = 0, n_fail = 0;

  // Reference model: frame position as a single cycle index, plus expected registered outputs.
  bit          m_run = 0;
  int          m_t = 0;
  logic        e_de = 0, e_hs = 1, e_vs = 1, e_uf = 0;
  logic [23:0] e_rgb = '0;

  logic [15:0] wq[$];
  int          iq[$];
  int          tbl_cur = -1;

  int c_pop = 0, c_fs = 0, c_hs = 0, c_vs = 0, cyc = 0, last_fs = -1, fs_period = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [27:0] obs();
    return {vga_de, vga_hsync, vga_vsync, underflow, vga_pixel_r, vga_pixel_g, vga_pixel_b};
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] w);
    int r5, g6, b5;
    r5 = int'(w) / 2048;
    g6 = (int'(w) / 32) % 64;
    b5 = int'(w) % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  // One pixel clock: called and returning at a falling edge.
  task automatic cycle(input logic en, input logic emp, input logic clr);
    int x, y, tnext;
    logic act, pop, fs_exp;
    logic [15:0] w;
    check("regs", 32'(obs()), 32'({e_de, e_hs, e_vs, e_uf, e_rgb}));
    if (tbl_cur >= 0)
      check("expand", 32'({vga_de, vga_pixel_r, vga_pixel_g, vga_pixel_b}),
            32'({1'b1, tbl[tbl_cur].r, tbl[tbl_cur].g, tbl[tbl_cur].b}));
    if (!vga_hsync) c_hs++;
    if (!vga_vsync) c_vs++;
    enable = en; seq_rd_empty = emp; underflow_clr = clr;
    #1;
    x = m_t % HT;
    y = m_t / HT;
    act = m_run && x < HA && y < VA;
    pop = act && !emp;
    fs_exp = m_run && m_t == 0;
    check("rd_en", 32'(seq_rd_en), 32'(pop));
    check("frame_start", 32'(frame_start), 32'(fs_exp));
    if (seq_rd_en) c_pop++;
    if (frame_start) begin
      c_fs++;
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
    tnext = -1;
    w = 16'($urandom);
    if (pop && wq.size() > 0) begin
      w = wq.pop_front();
      tnext = iq.pop_front();
    end
    e_de  = act;
    e_hs  = !(m_run && x >= HA + HF && x < HA + HF + HS);
    e_vs  = !(m_run && y >= VA + VF && y < VA + VF + VS);
    e_uf  = (act && emp) || (e_uf && !clr);
    e_rgb = pop ? expand(w) : 24'h0;
    if (!m_run) begin
      m_run = en;
      m_t = 0;
    end else if (m_t == FRAME - 1) begin
      m_t = 0;
      if (!en) m_run = 0;
    end else begin
      m_t++;
    end
    @(posedge clk);
    seq_rd_data = pop ? w : 16'($urandom);
    tbl_cur = tnext;
    cyc++;
    @(negedge clk);
  endtask

  task automatic advance_to(input int t);
    for (int i = 0; i < 2 * FRAME && !(m_run && m_t == t); i++) cycle(1'b1, 1'b0, 1'b0);
    check("advance", 32'(m_run && m_t == t), 32'd1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async", 32'({obs(), seq_rd_en, frame_start}), 32'({28'h6000000, 2'b00}));
    m_run = 0; m_t = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_uf = 0; e_rgb = '0;
    tbl_cur = -1;
    wq.delete(); iq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
    tbl[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{16'h8410, 8'h84, 8'h82, 8'h84};
    tbl[6] = '{16'h1234, 8'h10, 8'h45, 8'hA5};

    repeat (2) @(negedge clk);
    check("reset_state", 32'({obs(), seq_rd_en, frame_start}), 32'({28'h6000000, 2'b00}));
    rst = 1'b0;
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    // Full frames with a never-empty FIFO: pop, sync and frame-period counts.
    cycle(1'b1, 1'b0, 1'b0);
    c_pop = 0; c_fs = 0; c_hs = 0; c_vs = 0;
    repeat (HT) cycle(1'b1, 1'b0, 1'b0);
    check("pops_per_line", 32'(c_pop), 32'(HA));
    repeat (FRAME - HT) cycle(1'b1, 1'b0, 1'b0);
    check("pops_per_frame", 32'(c_pop), 32'(HA * VA));
    check("frame_starts", 32'(c_fs), 32'd1);
    check("hsync_low_clks", 32'(c_hs), 32'(HS * VT));
    check("vsync_low_clks", 32'(c_vs), 32'(VS * HT));
    repeat (FRAME) cycle(1'b1, 1'b0, 1'b0);
    check("frame_period", 32'(fs_period), 32'(FRAME));

    // Table vectors fed in pop order at the start of a frame.
    advance_to(0);
    for (int i = 0; i < 7; i++) begin
      wq.push_back(tbl[i].word);
      iq.push_back(i);
    end
    repeat (HT) cycle(1'b1, 1'b0, 1'b0);
    check("table_consumed", 32'(wq.size()), 32'd0);

    // Randomised empties and clears.
    repeat (2 * FRAME) cycle(1'b1, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);

    // Single underflow pixel, sticky flag, then clear.
    cycle(1'b1, 1'b0, 1'b1);
    check("uf_cleared", 32'(underflow), 32'd0);
    advance_to(HT + 5);
    cycle(1'b1, 1'b1, 1'b0);
    check("uf_pixel_black", 32'({vga_de, underflow, vga_pixel_r, vga_pixel_g, vga_pixel_b}),
          32'({2'b11, 24'h0}));
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    check("uf_sticky", 32'(underflow), 32'd1);
    cycle(1'b1, 1'b0, 1'b1);
    check("uf_clr", 32'(underflow), 32'd0);

    // Underflow and clear together: set wins.
    advance_to(2 * HT + 3);
    cycle(1'b1, 1'b1, 1'b1);
    check("uf_set_wins", 32'(underflow), 32'd1);
    cycle(1'b1, 1'b0, 1'b1);

    // Drop enable mid-frame: frame completes, then IDLE.
    advance_to(2 * HT);
    repeat (FRAME + 10) cycle(1'b0, 1'b0, 1'b0);
    c_pop = 0; c_fs = 0;
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    check("idle_no_pops", 32'(c_pop), 32'd0);
    check("idle_no_fs", 32'(c_fs), 32'd0);
    check("idle_outputs", 32'({vga_de, vga_hsync, vga_vsync, vga_pixel_r, vga_pixel_g, vga_pixel_b}),
          32'({3'b011, 24'h0}));

    // Asynchronous reset mid-frame, then restart.
    cycle(1'b1, 1'b0, 1'b0);
    advance_to(3 * HT + 10);
    cycle(1'b1, 1'b1, 1'b0);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0);
    check("fs_after_rst", 32'(frame_start), 32'd1);
    repeat (HT + 5) cycle(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
